// File: rtl/router_input_fifo.sv
// Per-port mesh router input buffer: RTS/CTS link intake, circular flit store.
// Optional ROUTER_INPUT_FIFO_ERR_EN adds sticky err_flags for illegal reads.
module router_input_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] RX,
   input  logic                  DRTS,
   input  logic                  read_en_N,
   input  logic                  read_en_E,
   input  logic                  read_en_W,
   input  logic                  read_en_S,
   input  logic                  read_en_L,
   output logic                  CTS,
   output logic                  empty,
   output logic                  full,
`ifdef ROUTER_INPUT_FIFO_ERR_EN
   output logic [1:0]            err_flags,
`endif
   output logic [DATA_WIDTH-1:0] Data_out
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

   typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         wr_ptr;
   logic [AW:0]           count;
   logic [4:0]            rd_vec;
   logic                  push;
   logic                  pop;

   assign rd_vec   = {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L};
   assign empty    = (count == '0);
   assign full     = (count == CNT_MAX);
   assign pop      = (|rd_vec) & ~empty;
   assign CTS      = (state == ACK);
   assign Data_out = mem[rd_ptr];

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      unique case (state)
         IDLE: begin
            if (DRTS && !full) begin
               push      = 1'b1;
               state_nxt = ACK;
            end
         end
         ACK: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state <= state_nxt;
         if (push) begin
            mem[wr_ptr] <= RX;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         unique case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

`ifdef ROUTER_INPUT_FIFO_ERR_EN
   logic multi_rd;

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_rd = ((rd_vec & (rd_vec - 5'd1)) != 5'd0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         err_flags <= 2'b00;
      end else begin
         if ((|rd_vec) && empty) err_flags[0] <= 1'b1;
         if (multi_rd)           err_flags[1] <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_router_input_fifo.sv
// Self-checking bench for router_input_fifo: vector table plus
// scoreboarded multi-cycle sequences (fill, wrap, push/pop overlap, errors).
module tb_router_input_fifo;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   localparam logic [4:0] RN = 5'b10000;
   localparam logic [4:0] RE = 5'b01000;
   localparam logic [4:0] RW = 5'b00100;
   localparam logic [4:0] RS = 5'b00010;
   localparam logic [4:0] RL = 5'b00001;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] RX;
   logic          DRTS;
   logic          read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
   logic          CTS, empty, full;
   logic [DW-1:0] Data_out;
`ifdef ROUTER_INPUT_FIFO_ERR_EN
   logic [1:0]    err_flags;
`endif

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] q [$];
   logic          m_cts;
   logic [1:0]    m_err;

   router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .RX        (RX),
      .DRTS      (DRTS),
      .read_en_N (read_en_N),
      .read_en_E (read_en_E),
      .read_en_W (read_en_W),
      .read_en_S (read_en_S),
      .read_en_L (read_en_L),
      .CTS       (CTS),
      .empty     (empty),
      .full      (full),
`ifdef ROUTER_INPUT_FIFO_ERR_EN
      .err_flags (err_flags),
`endif
      .Data_out  (Data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, score pops, advance model, compare after edge.
   task automatic cyc(input logic r, input logic d, input logic [DW-1:0] x,
                      input logic [4:0] re);
      logic m_push;
      logic m_pop;
      rst  = r;
      DRTS = d;
      RX   = x;
      {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = re;
      m_pop  = r && (|re) && (q.size() > 0);
      m_push = r && !m_cts && d && (q.size() < DEPTH);
      if (!r) begin
         m_err = 2'b00;
      end else begin
         if ((|re) && q.size() == 0) m_err[0] = 1'b1;
         if ($countones(re) > 1)      m_err[1] = 1'b1;
      end
      if (m_pop) check("pop_data", Data_out, q.pop_front());
      if (m_push) q.push_back(x);
      if (!r) q.delete();
      m_cts = m_push;
      @(posedge clk);
      #1;
      check("cts", {31'd0, CTS}, {31'd0, m_cts});
      check("empty", {31'd0, empty}, {31'd0, q.size() == 0});
      check("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
      if (!r) check("rst_data", Data_out, '0);
      else if (q.size() > 0) check("head", Data_out, q[0]);
`ifdef ROUTER_INPUT_FIFO_ERR_EN
      check("err_flags", {30'd0, err_flags}, {30'd0, m_err});
`endif
   endtask

   typedef struct {
      logic          r;
      logic          d;
      logic [DW-1:0] x;
      logic [4:0]    re;
      logic          e_cts;
      logic          e_empty;
      logic          e_full;
   } vec_t;

   initial begin
      vec_t          vecs [7];
      logic [DW-1:0] nx;

      rst = 1'b0; DRTS = 1'b0; RX = '0;
      {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = 5'b0;
      m_cts = 1'b0;
      m_err = 2'b00;

      vecs[0] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 5'b0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 32'hDEAD_BEEF, 5'b0, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 5'b0, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 32'h0000_00A5, 5'b0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_00A5, 5'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 32'h0,         RE,   1'b0, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 32'h0,         5'b0, 1'b0, 1'b1, 1'b0};

      @(posedge clk);
      #1;
      for (int i = 0; i < 7; i++) begin
         cyc(vecs[i].r, vecs[i].d, vecs[i].x, vecs[i].re);
         check($sformatf("vec%0d_cts", i), {31'd0, CTS}, {31'd0, vecs[i].e_cts});
         check($sformatf("vec%0d_empty", i), {31'd0, empty},
               {31'd0, vecs[i].e_empty});
         check($sformatf("vec%0d_full", i), {31'd0, full}, {31'd0, vecs[i].e_full});
         if (i == 4) check("single_head", Data_out, 32'h0000_00A5);
      end

      // Fill to DEPTH, fifth flit must wait for a pop.
      nx = 1;
      for (int c = 0; c < 12; c++) begin
         cyc(1'b1, 1'b1, nx, 5'b0);
         if (m_cts && nx < 5) nx++;
      end
      check("fill_full", {31'd0, full}, 32'd1);
      cyc(1'b1, 1'b1, nx, RN);
      check("fill_after_pop_cts", {31'd0, CTS}, 32'd0);
      cyc(1'b1, 1'b1, nx, 5'b0);
      check("flit5_cts", {31'd0, CTS}, 32'd1);
      check("flit5_head", Data_out, 32'd2);
      for (int c = 0; c < DEPTH; c++) cyc(1'b1, 1'b0, '0, RN);
      check("drained", {31'd0, empty}, 32'd1);

      // Wrap-around: six push/pop pairs, order checked by the scoreboard.
      for (int i = 1; i <= 6; i++) begin
         cyc(1'b1, 1'b1, 32'(i), 5'b0);
         check($sformatf("wrap%0d_head", i), Data_out, 32'(i));
         cyc(1'b1, 1'b0, '0, RL);
      end

      // Accept edge coincides with a pop at count 2.
      cyc(1'b1, 1'b1, 32'h21, 5'b0);
      cyc(1'b1, 1'b0, '0, 5'b0);
      cyc(1'b1, 1'b1, 32'h22, 5'b0);
      cyc(1'b1, 1'b0, '0, 5'b0);
      cyc(1'b1, 1'b1, 32'h23, RL);
      check("overlap_head", Data_out, 32'h22);
      cyc(1'b1, 1'b0, '0, RL);
      cyc(1'b1, 1'b0, '0, RL);
      check("overlap_drained", {31'd0, empty}, 32'd1);

      // Empty read, then multi-enable pop of a single flit.
      cyc(1'b1, 1'b0, '0, RW);
      cyc(1'b1, 1'b0, '0, 5'b0);
      cyc(1'b1, 1'b1, 32'h33, 5'b0);
      cyc(1'b1, 1'b0, '0, 5'b0);
      cyc(1'b1, 1'b0, '0, RN | RS);
      check("multi_single_pop", {31'd0, empty}, 32'd1);
      cyc(1'b1, 1'b0, '0, 5'b0);
      cyc(1'b1, 1'b0, '0, 5'b0);
`ifdef ROUTER_INPUT_FIFO_ERR_EN
      check("err_sticky", {30'd0, err_flags}, 32'd3);
`endif
      cyc(1'b0, 1'b0, '0, 5'b0);
      cyc(1'b1, 1'b0, '0, 5'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
